// File: rtl/cpu_mem.sv
// cpu_mem: synchronous single-port data memory with a valid/ready request
// port and a registered one-cycle read response. Every word is zeroed after
// reset by a self-clearing sweep. Define MEM_BIST_EN to compile in the
// write-pattern / read-compare self-test engine and its bist_* ports.
module cpu_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata
`ifdef MEM_BIST_EN
  ,
  input  logic                  bist_start,
  output logic                  bist_done,
  output logic                  bist_fail
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Pointer is one bit wider than the address so BIST_RD can spend one
  // extra cycle folding the last registered compare into bist_fail.
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] PAST = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, BIST_WR, BIST_RD} state_t;

  state_t                  state;
  logic [ADDR_WIDTH:0]     ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    we;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    bist_go;

`ifdef MEM_BIST_EN
  logic                    mis;

  // Test pattern: low DATA_WIDTH bits of the inverted zero-extended address.
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    logic [63:0] t;
    t = ~64'(a);
    return t[DATA_WIDTH-1:0];
  endfunction

  assign bist_go = bist_start;
`else
  assign bist_go = 1'b0;
`endif

  // Single write port mux: clear sweep, host write, or BIST pattern fill.
  always_comb begin
    we    = 1'b0;
    waddr = ptr[ADDR_WIDTH-1:0];
    wdata = '0;
    case (state)
      CLEAR: we = 1'b1;
      IDLE: begin
        // A concurrent bist_start wins; the request is not accepted.
        if (req_valid && req_ready && req_write && !bist_go) begin
          we    = 1'b1;
          waddr = req_addr;
          wdata = req_wdata;
        end
      end
`ifdef MEM_BIST_EN
      BIST_WR: begin
        we    = 1'b1;
        wdata = pat(ptr[ADDR_WIDTH-1:0]);
      end
`endif
      default: ;
    endcase
  end

  // Storage array: written on the clock only, never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Control FSM with registered ready/response/BIST status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEM_BIST_EN
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      mis       <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        CLEAR: begin
          if (ptr == LAST) begin
            ptr       <= '0;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        IDLE: begin
          if (bist_go) begin
`ifdef MEM_BIST_EN
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            mis       <= 1'b0;
            ptr       <= '0;
            state     <= BIST_WR;
            req_ready <= 1'b0;
`endif
          end else if (req_valid && req_ready && !req_write) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem[req_addr];
          end
        end
`ifdef MEM_BIST_EN
        BIST_WR: begin
          if (ptr == LAST) begin
            ptr   <= '0;
            state <= BIST_RD;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        BIST_RD: begin
          // Compare is registered in mis and folded in one cycle later.
          bist_fail <= bist_fail | mis;
          if (ptr == PAST) begin
            bist_done <= 1'b1;
            ptr       <= '0;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            mis <= (mem[ptr[ADDR_WIDTH-1:0]] != pat(ptr[ADDR_WIDTH-1:0]));
            ptr <= ptr + 1'b1;
          end
        end
`endif
        default: begin
          state     <= CLEAR;
          ptr       <= '0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem.sv
// tb_cpu_mem: randomized scoreboard bench for cpu_mem. Stimulus pushes the
// expected read data (from an array model of the memory) with its due cycle;
// a negedge monitor pops and compares whenever a response is due.
module tb_cpu_mem;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
`ifdef MEM_BIST_EN
  logic          bist_start = 1'b0;
  logic          bist_done;
  logic          bist_fail;
`endif

  cpu_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
`ifdef MEM_BIST_EN
    , .bist_start(bist_start), .bist_done(bist_done), .bist_fail(bist_fail)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] last_exp = '0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: a read response is due exactly one edge after its handshake.
  always @(negedge clk) begin
    if (rst) begin
      last_exp = '0;
    end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, e.data});
      last_exp = e.data;
    end else begin
      chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
      chk("rdata_hold", {24'b0, rsp_rdata}, {24'b0, last_exp});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request handshake; the model is updated in request order.
  task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    if (w) mdl[a] = d;
    else   exp_q.push_back('{data: mdl[a], due: cyc + 1});
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  // Release reset and measure how many edges the clear sweep keeps ready low.
  task automatic release_and_clear();
    int n;
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("clear_latency", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

`ifdef MEM_BIST_EN
  task automatic run_bist(input bit with_write);
    int n;
    bist_start = 1'b1;
    if (with_write) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd2; req_wdata = 8'h11;
    end
    tick();
    bist_start = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    chk("bist_ready_low", {31'b0, req_ready}, 32'd0);
    chk("bist_done_clr", {31'b0, bist_done}, 32'd0);
    n = 0;
    while (!bist_done && n < 300) begin
      tick();
      n++;
    end
    chk("bist_latency", n, 2 * DEPTH + 1);
    chk("bist_fail", {31'b0, bist_fail}, 32'd0);
    chk("bist_ready_back", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) mdl[i] = ~i[DW-1:0];
  endtask
`endif

  initial begin
    repeat (3) tick();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
`ifdef MEM_BIST_EN
    chk("rst_bist_done", {31'b0, bist_done}, 32'd0);
    chk("rst_bist_fail", {31'b0, bist_fail}, 32'd0);
`endif
    release_and_clear();

    // Cleared contents, then write i/read i back-to-back.
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, AW'(i), '0);
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, AW'(i), DW'(i));
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, AW'(i), '0);

    // Read-after-write forwarding, then a write must not pulse rsp_valid.
    do_req(1'b1, 5'd5, 8'hA5);
    do_req(1'b0, 5'd5, '0);
    do_req(1'b1, 5'd6, 8'h3C);
    tick();
    chk("a5_hold", {24'b0, rsp_rdata}, 32'hA5);

    // Randomized mix with idle gaps; narrow address range forces RAW hits.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) tick();
      else do_req($urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom),
                  DW'($urandom));
    end
    tick(); tick();

    // Reset mid-clear restarts the full sweep; old data is gone.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    chk("midclear_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b1; tick(); tick();
    release_and_clear();
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, AW'(i), '0);

`ifdef MEM_BIST_EN
    run_bist(1'b0);
    do_req(1'b0, 5'd3, '0);
    run_bist(1'b1);
    do_req(1'b0, 5'd2, '0);
    do_req(1'b0, 5'd31, '0);
    for (int k = 0; k < 40; k++)
      do_req($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
`endif

    tick(); tick(); tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
